pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard controller for a classic five-stage pipeline. It combines three
// hazard sources into per-stage enable/flush controls:
//   * data-memory wait: the whole pipeline freezes until the memory acks,
//     with an error abort after MEM_TIMEOUT cycles in MEM_WAIT;
//   * taken branch / jump resolved in EX: the two younger stages are flushed;
//   * load-use: IF and ID hold for one cycle while a bubble enters EX.
// Priority is freeze > branch flush > load-use.
//
// Parameters
//   MEM_TIMEOUT  cycles spent in MEM_WAIT without an ack before the abort
//   CNT_W        width of the saturating performance counters
//
// Ports
//   clk, reset         rising-edge clock, asynchronous active-low reset
//   id_rs1, id_rs2     ID-stage source register addresses
//   id_uses_rs1/rs2    ID instruction actually reads rs1 / rs2
//   ex_mem_read        EX-stage instruction is a load
//   ex_write_address   EX-stage destination register
//   ex_branch_taken    taken branch or jump resolved in EX
//   mem_req, mem_ack   MEM-stage data access request / completion
//   pc_en .. mem_wb_flush  pipeline register enables and bubble inserts
//   mem_err            one-cycle pulse when a memory access times out
//   ctrl_state         FSM state: RUN=00, MEM_WAIT=01, MEM_ERR=10
//   stall_cycles       saturating count of freeze and load-use cycles
//   flush_count        saturating count of applied branch flushes
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       id_rs1,
    input  logic [3:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [3:0]       ex_write_address,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_flush,
    output logic             mem_err,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        MEM_ERR  = 2'b10
    } state_t;

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t             state_q;
    state_t             state_nxt;
    logic [WAIT_W-1:0]  wait_cnt_q;
    logic [WAIT_W-1:0]  wait_cnt_nxt;
    logic               mem_err_q;
    logic [CNT_W-1:0]   stall_cnt_q;
    logic [CNT_W-1:0]   flush_cnt_q;

    logic               load_use_hit;
    logic               frozen;
    logic               branch_apply;
    logic               load_use_apply;

    // A load in EX whose destination is read by the instruction in ID.
    assign load_use_hit = ex_mem_read &&
                          ((id_uses_rs1 && (id_rs1 == ex_write_address)) ||
                           (id_uses_rs2 && (id_rs2 == ex_write_address)));

    // Freeze covers the RUN cycle in which a request first misses its ack as
    // well as every unacknowledged MEM_WAIT cycle. MEM_ERR never freezes.
    assign frozen = ((state_q == RUN)      && mem_req && !mem_ack) ||
                    ((state_q == MEM_WAIT) && !mem_ack);

    // The EX contents are held while frozen, so a taken branch is simply
    // deferred and takes effect on the release cycle.
    assign branch_apply   = !frozen && ex_branch_taken;
    assign load_use_apply = !frozen && !ex_branch_taken && load_use_hit;

    // -------------------------------------------------------------------------
    // Next-state and hazard outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case/if tree can leave a signal unassigned (no latches).
        state_nxt    = state_q;
        wait_cnt_nxt = wait_cnt_q;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b1;
        mem_wb_flush = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_req && !mem_ack) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = '0;
                end
            end
            MEM_WAIT: begin
                // An ack on the last allowed cycle still completes the access.
                if (mem_ack) begin
                    state_nxt = RUN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_nxt = MEM_ERR;
                end else begin
                    wait_cnt_nxt = wait_cnt_q + 1'b1;
                end
            end
            MEM_ERR: begin
                state_nxt = RUN;
            end
            default: begin
                // Unused encoding 2'b11 recovers to RUN on the next edge.
                state_nxt = RUN;
            end
        endcase

        if (frozen) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else begin
            if (branch_apply) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use_apply) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
            // The load that timed out carries garbage; drop it before WB.
            if (state_q == MEM_ERR) begin
                mem_wb_flush = 1'b1;
            end
        end

        // While held in reset the pipeline registers are all held and bubbled.
        if (!reset) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_en     = 1'b0;
            id_ex_flush  = 1'b1;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // State, wait counter and error pulse
    // -------------------------------------------------------------------------
    // NOTE: all control registers take the asynchronous reset; an access in
    // flight is abandoned silently, so mem_err can never pulse out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            state_q    <= state_nxt;
            wait_cnt_q <= wait_cnt_nxt;
            mem_err_q  <= (state_nxt == MEM_ERR);
        end
    end

    // -------------------------------------------------------------------------
    // Saturating performance counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((frozen || load_use_apply) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (branch_apply && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign mem_err      = mem_err_q;
    assign ctrl_state   = state_q;
    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Self-checking bench for pipeline_hazard_ctrl. A behavioural model (a
// "waiting" flag, a count of cycles spent waiting, an "error pending" flag and
// two integer counters) predicts every output each cycle. Directed scenarios
// also check hand-derived constants; a randomized run covers the rest,
// including counter saturation (the DUT is built with narrow counters).
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int TB_TIMEOUT = 8;
    localparam int TB_CNT_W   = 6;
    localparam int CNT_MAX    = (1 << TB_CNT_W) - 1;

    logic                clk;
    logic                reset;
    logic [3:0]          id_rs1;
    logic [3:0]          id_rs2;
    logic                id_uses_rs1;
    logic                id_uses_rs2;
    logic                ex_mem_read;
    logic [3:0]          ex_write_address;
    logic                ex_branch_taken;
    logic                mem_req;
    logic                mem_ack;
    logic                pc_en;
    logic                if_id_en;
    logic                if_id_flush;
    logic                id_ex_en;
    logic                id_ex_flush;
    logic                ex_mem_en;
    logic                mem_wb_flush;
    logic                mem_err;
    logic [1:0]          ctrl_state;
    logic [TB_CNT_W-1:0] stall_cycles;
    logic [TB_CNT_W-1:0] flush_count;

    int n_total = 0;
    int n_pass  = 0;

    // Model state
    bit m_wait;
    bit m_err;
    int m_waited;
    int m_stalls;
    int m_flushes;

    logic [9:0] obs_ctl;
    logic [9:0] exp_v;

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT (TB_TIMEOUT),
        .CNT_W       (TB_CNT_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_uses_rs1      (id_uses_rs1),
        .id_uses_rs2      (id_uses_rs2),
        .ex_mem_read      (ex_mem_read),
        .ex_write_address (ex_write_address),
        .ex_branch_taken  (ex_branch_taken),
        .mem_req          (mem_req),
        .mem_ack          (mem_ack),
        .pc_en            (pc_en),
        .if_id_en         (if_id_en),
        .if_id_flush      (if_id_flush),
        .id_ex_en         (id_ex_en),
        .id_ex_flush      (id_ex_flush),
        .ex_mem_en        (ex_mem_en),
        .mem_wb_flush     (mem_wb_flush),
        .mem_err          (mem_err),
        .ctrl_state       (ctrl_state),
        .stall_cycles     (stall_cycles),
        .flush_count      (flush_count)
    );

    assign obs_ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                      ex_mem_en, mem_wb_flush, mem_err, ctrl_state};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- model
    function automatic bit m_frozen();
        return (!m_wait && !m_err && mem_req && !mem_ack) || (m_wait && !mem_ack);
    endfunction

    function automatic bit m_hit();
        return ex_mem_read && ((id_uses_rs1 && id_rs1 == ex_write_address) ||
                               (id_uses_rs2 && id_rs2 == ex_write_address));
    endfunction

    // Expected {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
    //           ex_mem_en, mem_wb_flush, mem_err, ctrl_state}
    function automatic logic [9:0] exp_ctl();
        bit fr, br, lu;
        logic [1:0] st;
        if (!reset) return 10'b00_1_0_1_0_1_0_00;
        fr = m_frozen();
        br = !fr && ex_branch_taken;
        lu = !fr && !ex_branch_taken && m_hit();
        st = m_wait ? 2'b01 : (m_err ? 2'b10 : 2'b00);
        return {!(fr || lu), !(fr || lu), br, !fr, br || lu, !fr,
                fr || m_err, m_err, st};
    endfunction

    function automatic void model_reset();
        m_wait    = 1'b0;
        m_err     = 1'b0;
        m_waited  = 0;
        m_stalls  = 0;
        m_flushes = 0;
    endfunction

    function automatic void model_update();
        bit fr, br, lu;
        fr = m_frozen();
        br = !fr && ex_branch_taken;
        lu = !fr && !ex_branch_taken && m_hit();
        if (fr || lu) m_stalls  = (m_stalls  < CNT_MAX) ? m_stalls  + 1 : CNT_MAX;
        if (br)       m_flushes = (m_flushes < CNT_MAX) ? m_flushes + 1 : CNT_MAX;
        if (m_err) begin
            m_err = 1'b0;
        end else if (m_wait) begin
            if (mem_ack) begin
                m_wait = 1'b0;
            end else if (m_waited == TB_TIMEOUT - 1) begin
                m_wait = 1'b0;
                m_err  = 1'b1;
            end else begin
                m_waited++;
            end
        end else if (mem_req && !mem_ack) begin
            m_wait   = 1'b1;
            m_waited = 0;
        end
    endfunction

    // ------------------------------------------------------------- helpers
    task automatic set_idle();
        id_rs1           = 4'h0;
        id_rs2           = 4'h0;
        id_uses_rs1      = 1'b0;
        id_uses_rs2      = 1'b0;
        ex_mem_read      = 1'b0;
        ex_write_address = 4'h0;
        ex_branch_taken  = 1'b0;
        mem_req          = 1'b0;
        mem_ack          = 1'b0;
    endtask

    // Advance one clock: the model consumes the current inputs, then we move
    // to the next falling edge where new inputs get applied.
    task automatic tick();
        if (reset) model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        set_idle();
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // --------------------------------------------------------------- tests
    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        set_idle();
        model_reset();
        #1;
        n_total++;
        if (obs_ctl !== 10'b00_1_0_1_0_1_0_00)
            $display("FAIL reset_ctl: got %b want %b", obs_ctl, 10'b0010101000);
        else n_pass++;
        n_total++;
        if (stall_cycles !== '0 || flush_count !== '0)
            $display("FAIL reset_cnt: got stall=%0d flush=%0d want 0/0",
                     stall_cycles, flush_count);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_total++;
        if (obs_ctl !== 10'b11_0_1_0_1_0_0_00)
            $display("FAIL reset_release_idle: got %b want %b", obs_ctl, 10'b1101010000);
        else n_pass++;
    endtask

    task automatic test_load_use();
        apply_reset();
        ex_mem_read      = 1'b1;
        ex_write_address = 4'h3;
        id_rs2           = 4'h3;
        id_uses_rs2      = 1'b1;
        id_rs1           = 4'h5;
        id_uses_rs1      = 1'b1;
        #1;
        n_total++;
        if ({pc_en, if_id_en, id_ex_flush, id_ex_en, ex_mem_en, if_id_flush, mem_wb_flush} !== 7'b0011100)
            $display("FAIL load_use_stall: got %b want 0011100",
                     {pc_en, if_id_en, id_ex_flush, id_ex_en, ex_mem_en, if_id_flush, mem_wb_flush});
        else n_pass++;
        tick();
        // Bubble now in EX: no repeat stall.
        ex_mem_read = 1'b0;
        #1;
        n_total++;
        if (obs_ctl !== exp_ctl() || pc_en !== 1'b1)
            $display("FAIL load_use_bubble: got %b want %b", obs_ctl, exp_ctl());
        else n_pass++;
        n_total++;
        if (stall_cycles !== 6'd1)
            $display("FAIL load_use_count: got %0d want 1", stall_cycles);
        else n_pass++;
        // Matching address on an operand that is not read: no hazard.
        ex_mem_read = 1'b1;
        id_rs1      = 4'h3;
        id_uses_rs1 = 1'b0;
        id_rs2      = 4'h7;
        #1;
        n_total++;
        if (pc_en !== 1'b1 || id_ex_flush !== 1'b0)
            $display("FAIL load_use_unused_rs: got pc_en=%b id_ex_flush=%b want 1/0",
                     pc_en, id_ex_flush);
        else n_pass++;
        set_idle();
    endtask

    task automatic test_mem_wait();
        apply_reset();
        mem_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_total++;
            if (obs_ctl !== exp_ctl() || pc_en !== 1'b0 || mem_wb_flush !== 1'b1 ||
                ctrl_state !== ((k == 0) ? 2'b00 : 2'b01))
                $display("FAIL mem_wait_frozen[%0d]: got %b want %b", k, obs_ctl, exp_ctl());
            else n_pass++;
            tick();
        end
        mem_ack = 1'b1;
        #1;
        n_total++;
        if (obs_ctl !== 10'b11_0_1_0_1_0_0_01)
            $display("FAIL mem_wait_release: got %b want %b", obs_ctl, 10'b1101010001);
        else n_pass++;
        tick();
        mem_req = 1'b0;
        mem_ack = 1'b0;
        #1;
        n_total++;
        if (ctrl_state !== 2'b00 || stall_cycles !== 6'd3)
            $display("FAIL mem_wait_after: got state=%b stall=%0d want 00/3",
                     ctrl_state, stall_cycles);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int waits;
        bit err_seen;
        waits    = 0;
        err_seen = 1'b0;
        apply_reset();
        mem_req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i >= 9) mem_req = 1'b0;
            #1;
            n_total++;
            if (obs_ctl !== exp_ctl())
                $display("FAIL timeout_cycle[%0d]: got %b want %b", i, obs_ctl, exp_ctl());
            else n_pass++;
            if (ctrl_state == 2'b01) waits++;
            if (ctrl_state == 2'b10) begin
                err_seen = 1'b1;
                n_total++;
                if (i != 9 || mem_err !== 1'b1 || mem_wb_flush !== 1'b1 || pc_en !== 1'b1)
                    $display("FAIL timeout_err: at cycle %0d got mem_err=%b wb_flush=%b pc_en=%b want cycle 9, 1/1/1",
                             i, mem_err, mem_wb_flush, pc_en);
                else n_pass++;
            end
            tick();
        end
        n_total++;
        if (waits != TB_TIMEOUT || !err_seen)
            $display("FAIL timeout_len: got %0d wait cycles err_seen=%0d want %0d/1",
                     waits, err_seen, TB_TIMEOUT);
        else n_pass++;
        n_total++;
        if (ctrl_state !== 2'b00 || stall_cycles !== 6'd9 || mem_err !== 1'b0)
            $display("FAIL timeout_after: got state=%b stall=%0d err=%b want 00/9/0",
                     ctrl_state, stall_cycles, mem_err);
        else n_pass++;
    endtask

    task automatic test_branch_during_wait();
        apply_reset();
        mem_req         = 1'b1;
        ex_branch_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_ack = (i == 3);
            #1;
            n_total++;
            if (obs_ctl !== exp_ctl() ||
                if_id_flush !== (i == 3) || id_ex_flush !== (i == 3))
                $display("FAIL branch_wait[%0d]: got %b want %b", i, obs_ctl, exp_ctl());
            else n_pass++;
            tick();
        end
        mem_req         = 1'b0;
        mem_ack         = 1'b0;
        ex_branch_taken = 1'b0;
        #1;
        n_total++;
        if (flush_count !== 6'd1 || stall_cycles !== 6'd3)
            $display("FAIL branch_wait_count: got flush=%0d stall=%0d want 1/3",
                     flush_count, stall_cycles);
        else n_pass++;
    endtask

    task automatic test_branch_load_use();
        apply_reset();
        ex_branch_taken  = 1'b1;
        ex_mem_read      = 1'b1;
        ex_write_address = 4'hA;
        id_rs1           = 4'hA;
        id_uses_rs1      = 1'b1;
        #1;
        n_total++;
        if (obs_ctl !== 10'b11_1_1_1_1_0_0_00)
            $display("FAIL branch_load_use: got %b want %b", obs_ctl, 10'b1111110000);
        else n_pass++;
        tick();
        set_idle();
        #1;
        n_total++;
        if (stall_cycles !== 6'd0 || flush_count !== 6'd1)
            $display("FAIL branch_load_use_count: got stall=%0d flush=%0d want 0/1",
                     stall_cycles, flush_count);
        else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        mem_req         = 1'b1;
        ex_branch_taken = 1'b1;
        tick();
        tick();
        #1;
        n_total++;
        if (ctrl_state !== 2'b01)
            $display("FAIL mid_wait_pre: got state=%b want 01", ctrl_state);
        else n_pass++;
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        n_total++;
        if (ctrl_state !== 2'b00 || stall_cycles !== '0 || flush_count !== '0 || mem_err !== 1'b0)
            $display("FAIL mid_wait_reset: got state=%b stall=%0d flush=%0d err=%b want 00/0/0/0",
                     ctrl_state, stall_cycles, flush_count, mem_err);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        set_idle();
        for (int i = 0; i < 10; i++) begin
            #1;
            n_total++;
            if (ctrl_state !== 2'b00 || mem_err !== 1'b0)
                $display("FAIL mid_wait_after[%0d]: got state=%b err=%b want 00/0",
                         i, ctrl_state, mem_err);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 4000; c++) begin
            id_rs1           = 4'($urandom_range(0, 3));
            id_rs2           = 4'($urandom_range(0, 3));
            id_uses_rs1      = 1'($urandom_range(0, 1));
            id_uses_rs2      = 1'($urandom_range(0, 1));
            ex_mem_read      = 1'($urandom_range(0, 1));
            ex_write_address = 4'($urandom_range(0, 3));
            ex_branch_taken  = ($urandom_range(0, 5) == 0);
            mem_req          = ($urandom_range(0, 2) == 0);
            mem_ack          = ($urandom_range(0, 9) == 0);
            #1;
            exp_v = exp_ctl();
            n_total++;
            if (obs_ctl !== exp_v)
                $display("FAIL rand_ctl[%0d]: got %b want %b", c, obs_ctl, exp_v);
            else n_pass++;
            n_total++;
            if (stall_cycles !== TB_CNT_W'(m_stalls) || flush_count !== TB_CNT_W'(m_flushes))
                $display("FAIL rand_cnt[%0d]: got stall=%0d flush=%0d want %0d/%0d",
                         c, stall_cycles, flush_count, m_stalls, m_flushes);
            else n_pass++;
            tick();
        end
        n_total++;
        if (stall_cycles !== TB_CNT_W'(CNT_MAX) || flush_count !== TB_CNT_W'(CNT_MAX))
            $display("FAIL rand_saturate: got stall=%0d flush=%0d want %0d/%0d",
                     stall_cycles, flush_count, CNT_MAX, CNT_MAX);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b0;
        set_idle();
        model_reset();
        test_reset();
        test_load_use();
        test_mem_wait();
        test_timeout();
        test_branch_during_wait();
        test_branch_load_use();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
